// File: rtl/aggr_pkg.sv
// aggr_pkg: shared types for the aggregation line-buffer reader.
// Cost-vector geometry, column type and the per-read tag.
package aggr_pkg;

  localparam int CW     = 7;
  localparam int ND     = 64;
  localparam int DWIDTH = ND * CW;
  localparam int AWIDTH = 11;

  typedef logic [DWIDTH-1:0] cost_vec_t;
  typedef logic [AWIDTH-1:0] col_t;

  typedef struct packed {
    col_t col;
    logic first_row;
    logic fill;
  } lb_tag_t;

  // A zero width still has one column.
  function automatic col_t width_eff(col_t w);
    return (w == '0) ? col_t'(1) : w;
  endfunction

endpackage

// File: rtl/aggr_linebuf_reader_if.sv
// aggr_linebuf_reader_if: valid/ready stream of cost vectors.
// master: producer (out_valid/out_data/out_col/out_first_row, takes out_ready)
// slave : consumer (takes the vector, drives out_ready)
interface aggr_linebuf_reader_if;
  import aggr_pkg::*;

  logic      out_valid;
  logic      out_ready;
  cost_vec_t out_data;
  col_t      out_col;
  logic      out_first_row;

  modport master (
    output out_valid, out_data, out_col, out_first_row,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_col, out_first_row,
    output out_ready
  );

endinterface

// File: rtl/aggr_linebuf_reader_tag_fifo.sv
// aggr_tag_fifo: synchronous show-ahead FIFO with occupancy count.
// Ports: clk, rst (async, low), push/din, pop/dout (head), count, full.
module aggr_tag_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rp;
  logic [AW-1:0]    wp;
  logic             wr;
  logic             rd;

  assign full = (count == NW'(DEPTH));
  assign rd   = pop && (count != '0);
  // A pop frees the slot the push lands in.
  assign wr   = push && (!full || rd);
  assign dout = mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (rd)
        rp <= rp + AW'(1);
      unique case (1'b1)
        wr && !rd: count <= count + NW'(1);
        rd && !wr: count <= count - NW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aggr_linebuf_reader.sv
// aggr_linebuf_reader: reads previous-row cost vectors from the
// line-buffer SRAM, realigns read latency, streams them out tagged.
// Ports: clk, rst (async, low), width, frame_start,
//   in_valid/in_ready request, sram_ceb/sram_addr/sram_q,
//   down (stream master), overflow (sticky).
// Build option ROW0_FILL_EN: row-0 requests skip the SRAM and
//   deliver all-ones vectors instead of raw sram_q.
module aggr_linebuf_reader
  import aggr_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  col_t                         width,
  input  logic                         frame_start,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         sram_ceb,
  output col_t                         sram_addr,
  input  cost_vec_t                    sram_q,
  aggr_linebuf_reader_if.master        down,
  output logic                         overflow
);

  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = DWIDTH + AWIDTH + 1;
  localparam logic [NW:0] DEPTH_C = (NW+1)'(FIFO_DEPTH);

  col_t        col;
  col_t        width_l;
  logic        row;
  col_t        cur_col;
  col_t        cur_w;
  logic        cur_row;
  logic        first_row;
  logic        fill;
  logic        acc;
  lb_tag_t     tag_in;
  logic [RD_LAT:1] tv;
  lb_tag_t     tt [1:RD_LAT];
  lb_tag_t     ptag;
  cost_vec_t   pdata;
  logic [NW-1:0] fcnt;
  logic [NW:0] used;
  logic        push;
  logic        pop;
  logic        full;
  logic [FW-1:0] din;
  logic [FW-1:0] dout;

  // Reads in the tag pipe plus FIFO entries never exceed the depth,
  // so a push always finds room.
  always_comb begin
    used = {1'b0, fcnt};
    for (int i = 1; i <= RD_LAT; i++)
      used = used + (NW+1)'(tv[i]);
  end

  assign in_ready = (used < DEPTH_C);
  assign acc      = in_valid && in_ready && rst;

  // frame_start restarts the counters for an accept in the same cycle.
  assign cur_col   = frame_start ? '0 : col;
  assign cur_row   = frame_start ? 1'b0 : row;
  assign cur_w     = frame_start ? width_eff(width) : width_l;
  assign first_row = !cur_row;

`ifdef ROW0_FILL_EN
  assign fill = first_row;
`else
  assign fill = 1'b0;
`endif

  assign sram_ceb  = !(acc && !fill);
  assign sram_addr = cur_col;
  assign tag_in    = {cur_col, first_row, fill};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col     <= '0;
      row     <= 1'b0;
      width_l <= col_t'(1);
    end else begin
      if (frame_start)
        width_l <= width_eff(width);
      if (acc) begin
        if (cur_col == cur_w - col_t'(1)) begin
          col <= '0;
          row <= 1'b1;
        end else begin
          col <= cur_col + col_t'(1);
          row <= cur_row;
        end
      end else if (frame_start) begin
        col <= '0;
        row <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tv <= '0;
      for (int i = 1; i <= RD_LAT; i++)
        tt[i] <= '0;
    end else begin
      tv[1] <= acc;
      tt[1] <= tag_in;
      for (int i = 2; i <= RD_LAT; i++) begin
        tv[i] <= tv[i-1];
        tt[i] <= tt[i-1];
      end
    end
  end

  assign ptag  = tt[RD_LAT];
  assign pdata = ptag.fill ? '1 : sram_q;
  assign push  = tv[RD_LAT];
  assign din   = {pdata, ptag.col, ptag.first_row};
  assign pop   = down.out_valid && down.out_ready;

  aggr_tag_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .count (fcnt),
    .full  (full)
  );

  assign down.out_valid     = (fcnt != '0);
  assign down.out_first_row = dout[0];
  assign down.out_col       = dout[AWIDTH:1];
  assign down.out_data      = dout[FW-1:AWIDTH+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overflow <= 1'b0;
    else if (push && full && !pop)
      overflow <= 1'b1;
  end

endmodule

// File: tb/tb_aggr_linebuf_reader.sv
// tb_aggr_linebuf_reader: directed bench for aggr_linebuf_reader.
// Two instances: RD_LAT=1 (scoreboarded) and RD_LAT=3 (credits).
module tb_aggr_linebuf_reader;
  import aggr_pkg::*;

`ifdef ROW0_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst;
  col_t      w1, w3;
  logic      fs1, fs3, iv1, iv3, ir1, ir3;
  logic      ceb1, ceb3, ov1, ov3;
  col_t      addr1, addr3;
  cost_vec_t q1, q3;
  cost_vec_t p3 [3];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    col_t col;
    bit   fr;
    int   t;
  } exp_t;

  exp_t eq[$];
  int   m_col = 0;
  int   m_w   = 1;
  bit   m_row1 = 1'b0;

  aggr_linebuf_reader_if l1 ();
  aggr_linebuf_reader_if l3 ();

  aggr_linebuf_reader #(
    .RD_LAT     (1),
    .FIFO_DEPTH (4)
  ) u_d1 (
    .clk         (clk),
    .rst         (rst),
    .width       (w1),
    .frame_start (fs1),
    .in_valid    (iv1),
    .in_ready    (ir1),
    .sram_ceb    (ceb1),
    .sram_addr   (addr1),
    .sram_q      (q1),
    .down        (l1),
    .overflow    (ov1)
  );

  aggr_linebuf_reader #(
    .RD_LAT     (3),
    .FIFO_DEPTH (4)
  ) u_d3 (
    .clk         (clk),
    .rst         (rst),
    .width       (w3),
    .frame_start (fs3),
    .in_valid    (iv3),
    .in_ready    (ir3),
    .sram_ceb    (ceb3),
    .sram_addr   (addr3),
    .sram_q      (q3),
    .down        (l3),
    .overflow    (ov3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic cost_vec_t pat(col_t a);
    return {14{a, ~a, 10'h2a5}};
  endfunction

  function automatic cost_vec_t expd(col_t c, bit fr);
    return (FILL && fr) ? '1 : pat(c);
  endfunction

  // SRAM models: address-tagged data, zero when not read
  always @(posedge clk) q1 <= ceb1 ? '0 : pat(addr1);

  always @(posedge clk) begin
    p3[0] <= ceb3 ? '0 : pat(addr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign q3 = p3[2];

  task automatic chk(string tag, logic [DWIDTH-1:0] got,
                     logic [DWIDTH-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rst_chk(string s);
    chk({s, "_ceb"},  ceb1, 1'b1);
    chk({s, "_addr"}, addr1, '0);
    chk({s, "_ovld"}, l1.out_valid, 1'b0);
    chk({s, "_odat"}, l1.out_data, '0);
    chk({s, "_ocol"}, l1.out_col, '0);
    chk({s, "_ofr"},  l1.out_first_row, 1'b0);
    chk({s, "_ovf"},  ov1, 1'b0);
    chk({s, "_rdy"},  ir1, 1'b1);
  endtask

  // Per-cycle check of d1 against the bench model.
  task automatic mon(output bit acc);
    exp_t e;
    exp_t h;
    bit   rdy;
    bit   ev;
    #1;
    rdy = eq.size() < 4;
    chk("in_ready", ir1, rdy);
    ev = (eq.size() > 0) && (eq[0].t + 2 <= cyc);
    chk("out_valid", l1.out_valid, ev);
    if (ev) begin
      h = eq[0];
      chk("out_col", l1.out_col, h.col);
      chk("out_first_row", l1.out_first_row, h.fr);
      chk("out_data", l1.out_data, expd(h.col, h.fr));
      if (l1.out_ready)
        void'(eq.pop_front());
    end
    if (fs1) begin
      m_col  = 0;
      m_row1 = 1'b0;
      m_w    = (w1 == '0) ? 1 : int'(w1);
    end
    acc = iv1 && rdy;
    if (acc) begin
      e.col = col_t'(m_col);
      e.fr  = !m_row1;
      e.t   = cyc;
      chk("sram_ceb", ceb1, FILL && e.fr);
      if (!(FILL && e.fr))
        chk("sram_addr", addr1, e.col);
      eq.push_back(e);
      if (m_col == m_w - 1) begin
        m_col  = 0;
        m_row1 = 1'b1;
      end else begin
        m_col++;
      end
    end else begin
      chk("sram_ceb_idle", ceb1, 1'b1);
    end
    chk("overflow", ov1, 1'b0);
  endtask

  task automatic cycle1(bit fs, bit iv, bit ordy, output bit acc);
    @(negedge clk);
    fs1 = fs;
    iv1 = iv;
    l1.out_ready = ordy;
    mon(acc);
  endtask

  task automatic go(int n, int pct);
    int got;
    bit a;
    got = 0;
    for (int k = 0; k < 40 * n + 40 && got < n; k++) begin
      cycle1(1'b0, 1'b1, $urandom_range(99) < pct, a);
      got += int'(a);
    end
    if (got != n)
      chk("accept_budget", got, n);
  endtask

  task automatic drain();
    bit a;
    for (int k = 0; k < 50 && eq.size() > 0; k++)
      cycle1(1'b0, 1'b0, 1'b1, a);
    chk("drained", eq.size(), 0);
  endtask

  initial begin
    bit a;
    rst = 1'b0;
    w1 = '0; w3 = '0;
    fs1 = 1'b0; fs3 = 1'b0;
    iv1 = 1'b0; iv3 = 1'b0;
    l1.out_ready = 1'b0;
    l3.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_chk("reset");
    chk("reset3_ceb", ceb3, 1'b1);
    chk("reset3_rdy", ir3, 1'b1);
    chk("reset3_ovld", l3.out_valid, 1'b0);
    chk("reset3_ovf", ov3, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // 1: width 4, 12 accepts, out_ready held
    w1 = 11'd4;
    cycle1(1'b1, 1'b1, 1'b1, a);
    go(11, 100);
    drain();

    // 2: RD_LAT=3 credit exhaustion and drain
    w3 = 11'd16;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fs3 = (i == 0);
      iv3 = 1'b1;
      l3.out_ready = 1'b0;
      #1;
      chk("t2_rdy", ir3, i < 4);
      chk("t2_ceb", ceb3, (i >= 4) || FILL);
      if (i < 4 && !FILL)
        chk("t2_addr", addr3, i);
      chk("t2_ovld", l3.out_valid, i >= 4);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fs3 = 1'b0;
      iv3 = 1'b0;
      l3.out_ready = 1'b1;
      #1;
      chk("t2_ovld_dr", l3.out_valid, i < 4);
      chk("t2_rdy_ret", ir3, i > 0);
      if (i < 4) begin
        chk("t2_col", l3.out_col, i);
        chk("t2_fr", l3.out_first_row, 1'b1);
        chk("t2_data", l3.out_data, expd(col_t'(i), 1'b1));
      end
    end
    chk("t2_ovf", ov3, 1'b0);

    // 3: random backpressure, 1000 accepts
    w1 = 11'd13;
    cycle1(1'b1, 1'b1, 1'b1, a);
    go(999, 50);
    drain();

    // 4: frame_start at col 2 with 3 reads outstanding
    w1 = 11'd4;
    cycle1(1'b1, 1'b1, 1'b1, a);
    go(2, 100);
    drain();
    go(3, 0);
    cycle1(1'b1, 1'b1, 1'b0, a);
    go(3, 100);
    drain();

    // 5: width 0 and width 1
    w1 = 11'd0;
    cycle1(1'b1, 1'b1, 1'b1, a);
    go(4, 100);
    drain();
    w1 = 11'd1;
    cycle1(1'b1, 1'b1, 1'b1, a);
    go(3, 100);
    drain();

    // 6: row-0 data path, then reset mid-stream
    w1 = 11'd3;
    cycle1(1'b1, 1'b1, 1'b1, a);
    go(5, 100);
    @(negedge clk);
    fs1 = 1'b0;
    iv1 = 1'b1;
    l1.out_ready = 1'b1;
    rst = 1'b0;
    #1;
    rst_chk("midrst");
    eq.delete();
    m_col  = 0;
    m_row1 = 1'b0;
    m_w    = 1;
    @(negedge clk);
    rst = 1'b1;
    iv1 = 1'b0;
    w1 = 11'd5;
    cycle1(1'b1, 1'b1, 1'b1, a);
    go(6, 100);
    drain();
    chk("end_ovf3", ov3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
    $finish;
  end

endmodule
